west_ram_rd_queue: RTL and testbench
====================================

# west_ram_rd_queue

Per-bank read command queue and response buffer sitting between the west read-command select stage and the eight west data-RAM banks. Accepts the one-hot-per-pair read commands (`toram_west_rd_cmd_vld/pld`, 8 lanes) and buffers them per lane. Issues them to the RAM when the bank is not claimed by a write. Captures the read data after the fixed RAM latency and presents it with its original payload on a valid/ready response port. Returns one credit per command issued, so upstream arbiters never overrun a lane.

## Interface
Parameters:
- `NUM_RAM`, 8: number of lanes/banks.
- `CMD_DEPTH`, 4: command FIFO entries per lane (power of two).
- `RSP_DEPTH`, 4: response buffer entries per lane (power of two).
- `RD_LAT`, 2: cycles from `ram_rd_en` to valid `ram_rd_data` (≥1).
- `DATA_W`, 256: RAM data width.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `toram_west_rd_cmd_vld` in [NUM_RAM]: per-lane command push.
- `toram_west_rd_cmd_pld` in arb_out_req_t[NUM_RAM]: command payload, stored opaque.
- `rd_cmd_credit_rtn` out [NUM_RAM]: 1-cycle pulse per command issued to RAM.
- `ram_wr_busy` in [NUM_RAM]: bank used by write this cycle; blocks issue.
- `ram_rd_en` out [NUM_RAM]: RAM read strobe.
- `ram_rd_pld` out arb_out_req_t[NUM_RAM]: payload of the issued command (RAM takes index from it).
- `ram_rd_data` in [NUM_RAM][DATA_W]: valid exactly RD_LAT cycles after `ram_rd_en`.
- `rd_rsp_vld` out [NUM_RAM], `rd_rsp_rdy` in [NUM_RAM]: response handshake.
- `rd_rsp_pld` out arb_out_req_t[NUM_RAM], `rd_rsp_data` out [NUM_RAM][DATA_W]: response contents.
- `cmd_ovf_err` out [NUM_RAM]: sticky overflow flag.

## Operation
Lanes are fully independent; all rules below are per lane.
- **Push:** `vld` writes pld to the command FIFO tail. Push while FIFO full (registered count == CMD_DEPTH) drops the command and sets `cmd_ovf_err`, even if a pop happens in the same cycle. A simulation assertion fires on this condition. No push-to-issue bypass.
- **Issue:** `ram_rd_en = !fifo_empty && !ram_wr_busy && (inflight_cnt + rsp_cnt < RSP_DEPTH)`, all terms registered state.
  - On issue: pop the head, drive `ram_rd_pld` = head, pulse `rd_cmd_credit_rtn`.
  - Issue is in order, at most one per cycle.
- **In-flight tracking:** RD_LAT-deep valid+pld shift register; `inflight_cnt` = number of set valid bits (0..RD_LAT).
- **Capture:** when the shift register's last stage is valid, write {pld, `ram_rd_data`} to the response buffer. The reservation rule guarantees this buffer is never full at capture; a full buffer at capture is an assertion error.
- **Response:** `rd_rsp_*` shows the buffer head. Pop on `vld && rdy`. Once `rd_rsp_vld` is asserted, `pld`/`data` stay stable until the pop.
- **Counters:** FIFO pointers are log2(depth)+1 bits and wrap naturally. Counts update as +push −pop in the same cycle.

## Timing
- Reset values: `ram_rd_en`, `rd_cmd_credit_rtn`, `rd_rsp_vld`, `cmd_ovf_err` = 0. `ram_rd_pld`, `rd_rsp_pld`, `rd_rsp_data` = 0. FIFOs empty, shift register cleared.
- Push at cycle T gives earliest `ram_rd_en` at T+1.
- Issue at T gives `ram_rd_data` sampled at T+RD_LAT and `rd_rsp_vld` at T+RD_LAT+1.
- Minimum push→response latency is RD_LAT+2 = 4 cycles at default.
- Sustained throughput is 1 per cycle when `rdy` is held high and `ram_wr_busy` is low.
- `ram_wr_busy` high stalls issue only; in-flight reads complete normally.
- `rd_rsp_rdy` low for long enough: issue halts once inflight+rsp reaches RSP_DEPTH, and credits stop.
- `rst` asserted mid-operation: all state clears asynchronously. Data returning after reset release from pre-reset reads is ignored.
- `cmd_ovf_err` clears only on reset.

## Test plan
- **Single read, lane 3:** push at T=0 → `ram_rd_en[3]` and credit at T=1; `rd_rsp_vld[3]` at T=4 with matching pld and data 0xA5…; no activity on other lanes.
- **Back-to-back:** lane 0, 4 pushes T=0..3, `rdy`=1 → `ram_rd_en` T=1..4, responses T=4..7 in push order, 4 credit pulses.
- **Write block:** `ram_wr_busy[5]`=1 for T=1..3 with a push at T=0 → issue at T=4, response at T=7.
- **Backpressure:** `rd_rsp_rdy[2]`=0 with 8 pushes → exactly 4 issues/credits, 4 buffered. Release `rdy` → remaining 4 drain, 8 responses in order, no data loss.
- **Overflow:** 5 pushes on lane 1 in consecutive cycles with `ram_wr_busy[1]`=1 → 5th dropped, `cmd_ovf_err[1]`=1 sticky; the 4 kept commands complete after busy drops.
- **Mid-flight reset:** `rst` pulse one cycle after issue → all outputs 0. No response appears for the pre-reset read; a new push after reset behaves as in the single-read case.

Source files
------------

// File: rtl/west_ram_rd_queue.sv
// West data-RAM read queue: per-lane command FIFO, write-aware RAM issue with
// response-slot reservation, fixed-latency capture and a valid/ready response buffer.
package west_ram_rd_queue_pkg;
  typedef struct packed {
    logic [3:0]  src;
    logic [11:0] addr;
  } arb_out_req_t;
endpackage

module west_ram_rd_queue
  import west_ram_rd_queue_pkg::*;
#(
  parameter int NUM_RAM   = 8,
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int RD_LAT    = 2,
  parameter int DATA_W    = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RAM-1:0]   toram_west_rd_cmd_vld,
  input  arb_out_req_t         toram_west_rd_cmd_pld [NUM_RAM],
  output logic [NUM_RAM-1:0]   rd_cmd_credit_rtn,
  input  logic [NUM_RAM-1:0]   ram_wr_busy,
  output logic [NUM_RAM-1:0]   ram_rd_en,
  output arb_out_req_t         ram_rd_pld [NUM_RAM],
  input  logic [DATA_W-1:0]    ram_rd_data [NUM_RAM],
  output logic [NUM_RAM-1:0]   rd_rsp_vld,
  input  logic [NUM_RAM-1:0]   rd_rsp_rdy,
  output arb_out_req_t         rd_rsp_pld [NUM_RAM],
  output logic [DATA_W-1:0]    rd_rsp_data [NUM_RAM],
  output logic [NUM_RAM-1:0]   cmd_ovf_err
);

  localparam int CAW  = $clog2(CMD_DEPTH);
  localparam int RAW  = $clog2(RSP_DEPTH);
  localparam int SUMW = $clog2(RD_LAT + RSP_DEPTH + 1) + 1;

  for (genvar g = 0; g < NUM_RAM; g++) begin : g_lane
    arb_out_req_t      cmd_mem_q [CMD_DEPTH];
    logic [CAW:0]      cmd_wr_ptr_q, cmd_wr_ptr_d;
    logic [CAW:0]      cmd_rd_ptr_q, cmd_rd_ptr_d;
    logic [CAW:0]      cmd_cnt;
    logic              cmd_full, cmd_empty;
    logic              push, ovf, issue;
    logic              ovf_err_q, ovf_err_d;
    arb_out_req_t      cmd_head;

    logic [RD_LAT-1:0] sr_vld_q;
    arb_out_req_t      sr_pld_q [RD_LAT];
    logic [SUMW-1:0]   inflight_cnt;
    logic [SUMW-1:0]   reserved_cnt;
    logic              capture;

    arb_out_req_t      rsp_pld_mem_q [RSP_DEPTH];
    logic [DATA_W-1:0] rsp_data_mem_q [RSP_DEPTH];
    logic [RAW:0]      rsp_wr_ptr_q, rsp_wr_ptr_d;
    logic [RAW:0]      rsp_rd_ptr_q, rsp_rd_ptr_d;
    logic [RAW:0]      rsp_cnt;
    logic              rsp_full, rsp_empty, rsp_pop;

    // Command FIFO: a push into a full FIFO is dropped even if the head pops this cycle.
    assign cmd_cnt   = cmd_wr_ptr_q - cmd_rd_ptr_q;
    assign cmd_full  = (cmd_cnt == (CAW+1)'(CMD_DEPTH));
    assign cmd_empty = (cmd_cnt == '0);
    assign push      = toram_west_rd_cmd_vld[g] && !cmd_full;
    assign ovf       = toram_west_rd_cmd_vld[g] && cmd_full;
    assign cmd_head  = cmd_mem_q[cmd_rd_ptr_q[CAW-1:0]];

    always_comb begin
      inflight_cnt = '0;
      for (int i = 0; i < RD_LAT; i++) begin
        inflight_cnt = inflight_cnt + SUMW'(sr_vld_q[i]);
      end
    end

    // Every read in flight already owns a response slot, so capture never finds the buffer full.
    assign rsp_cnt      = rsp_wr_ptr_q - rsp_rd_ptr_q;
    assign reserved_cnt = inflight_cnt + SUMW'(rsp_cnt);
    assign issue        = !cmd_empty && !ram_wr_busy[g] && (reserved_cnt < SUMW'(RSP_DEPTH));

    assign capture   = sr_vld_q[RD_LAT-1];
    assign rsp_full  = (rsp_cnt == (RAW+1)'(RSP_DEPTH));
    assign rsp_empty = (rsp_cnt == '0);
    // Response port: data moves only on rd_rsp_vld && rd_rsp_rdy; while vld is high and
    // rdy is low the head entry (pld and data) is held unchanged.
    assign rsp_pop   = !rsp_empty && rd_rsp_rdy[g];

    assign cmd_wr_ptr_d = cmd_wr_ptr_q + (CAW+1)'(push);
    assign cmd_rd_ptr_d = cmd_rd_ptr_q + (CAW+1)'(issue);
    assign rsp_wr_ptr_d = rsp_wr_ptr_q + (RAW+1)'(capture);
    assign rsp_rd_ptr_d = rsp_rd_ptr_q + (RAW+1)'(rsp_pop);
    assign ovf_err_d    = ovf_err_q || ovf;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cmd_wr_ptr_q <= '0;
        cmd_rd_ptr_q <= '0;
        rsp_wr_ptr_q <= '0;
        rsp_rd_ptr_q <= '0;
        ovf_err_q    <= 1'b0;
        sr_vld_q     <= '0;
      end else begin
        cmd_wr_ptr_q <= cmd_wr_ptr_d;
        cmd_rd_ptr_q <= cmd_rd_ptr_d;
        rsp_wr_ptr_q <= rsp_wr_ptr_d;
        rsp_rd_ptr_q <= rsp_rd_ptr_d;
        ovf_err_q    <= ovf_err_d;
        sr_vld_q[0]  <= issue;
        for (int i = 1; i < RD_LAT; i++) begin
          sr_vld_q[i] <= sr_vld_q[i-1];
        end
      end
    end

    // Storage arrays carry no reset; every read of them is qualified by a reset-cleared valid.
    always_ff @(posedge clk) begin
      if (push) begin
        cmd_mem_q[cmd_wr_ptr_q[CAW-1:0]] <= toram_west_rd_cmd_pld[g];
      end
      sr_pld_q[0] <= cmd_head;
      for (int i = 1; i < RD_LAT; i++) begin
        sr_pld_q[i] <= sr_pld_q[i-1];
      end
      if (capture) begin
        rsp_pld_mem_q[rsp_wr_ptr_q[RAW-1:0]]  <= sr_pld_q[RD_LAT-1];
        rsp_data_mem_q[rsp_wr_ptr_q[RAW-1:0]] <= ram_rd_data[g];
      end
    end

    assign ram_rd_en[g]         = issue;
    assign rd_cmd_credit_rtn[g] = issue;
    assign ram_rd_pld[g]        = issue ? cmd_head : '0;
    assign rd_rsp_vld[g]        = !rsp_empty;
    assign rd_rsp_pld[g]        = rsp_empty ? '0 : rsp_pld_mem_q[rsp_rd_ptr_q[RAW-1:0]];
    assign rd_rsp_data[g]       = rsp_empty ? '0 : rsp_data_mem_q[rsp_rd_ptr_q[RAW-1:0]];
    assign cmd_ovf_err[g]       = ovf_err_q;

    always @(posedge clk) begin
      if (!rst) begin
        assert (!ovf)
          else $warning("west_ram_rd_queue lane %0d: command pushed while FIFO full, dropped", g);
        assert (!(capture && rsp_full))
          else $error("west_ram_rd_queue lane %0d: read data captured into a full response buffer", g);
      end
    end
  end

endmodule

// File: tb/tb_west_ram_rd_queue.sv
// Bench for west_ram_rd_queue: cycle-exact vector table, a fixed-latency RAM model,
// and a per-lane response scoreboard.
`timescale 1ns/1ps
module tb_west_ram_rd_queue;
  import west_ram_rd_queue_pkg::*;

  localparam int NUM_RAM   = 8;
  localparam int CMD_DEPTH = 4;
  localparam int RSP_DEPTH = 4;
  localparam int RD_LAT    = 2;
  localparam int DATA_W    = 256;
  localparam int EW        = 16 + DATA_W;
  localparam int CW        = 320;

  logic clk = 1'b0;
  logic rst;
  logic [NUM_RAM-1:0] cmd_vld, credit, wr_busy, rd_en, rsp_vld, rsp_rdy, ovf_err;
  arb_out_req_t       cmd_pld [NUM_RAM];
  arb_out_req_t       rd_pld  [NUM_RAM];
  arb_out_req_t       rsp_pld [NUM_RAM];
  logic [DATA_W-1:0]  rd_data [NUM_RAM];
  logic [DATA_W-1:0]  rsp_data [NUM_RAM];

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q [NUM_RAM][$];
  int iss_cnt [NUM_RAM];
  int cr_cnt  [NUM_RAM];
  int s_iss, s_cr;
  int s_all [NUM_RAM];

  typedef struct {
    logic [NUM_RAM-1:0] vld;
    logic [NUM_RAM-1:0] busy;
    logic [NUM_RAM-1:0] rdy;
    logic [NUM_RAM-1:0] en;
    logic [NUM_RAM-1:0] cr;
    logic [NUM_RAM-1:0] rsp;
  } vec_t;
  vec_t tbl [24];

  west_ram_rd_queue #(
    .NUM_RAM(NUM_RAM), .CMD_DEPTH(CMD_DEPTH), .RSP_DEPTH(RSP_DEPTH),
    .RD_LAT(RD_LAT), .DATA_W(DATA_W)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .toram_west_rd_cmd_vld (cmd_vld),
    .toram_west_rd_cmd_pld (cmd_pld),
    .rd_cmd_credit_rtn     (credit),
    .ram_wr_busy           (wr_busy),
    .ram_rd_en             (rd_en),
    .ram_rd_pld            (rd_pld),
    .ram_rd_data           (rd_data),
    .rd_rsp_vld            (rsp_vld),
    .rd_rsp_rdy            (rsp_rdy),
    .rd_rsp_pld            (rsp_pld),
    .rd_rsp_data           (rsp_data),
    .cmd_ovf_err           (ovf_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic logic [DATA_W-1:0] ram_data(input int lane, input arb_out_req_t p);
    logic [DATA_W-1:0] d;
    d = {(DATA_W/8){8'hA5}};
    d[15:0] = d[15:0] ^ p;
    d[DATA_W-1 -: 8] = 8'(lane);
    return d;
  endfunction

  function automatic logic all_empty();
    logic e;
    e = 1'b1;
    for (int l = 0; l < NUM_RAM; l++) begin
      if (exp_q[l].size() != 0) e = 1'b0;
    end
    return e;
  endfunction

  // ---------------- RAM model: data valid RD_LAT cycles after ram_rd_en ----------------
  logic [NUM_RAM-1:0] pend_vld;
  arb_out_req_t       pend_pld [NUM_RAM];
  logic [RD_LAT-1:0]  pipe_vld [NUM_RAM];
  logic [DATA_W-1:0]  pipe_data [NUM_RAM][RD_LAT];

  initial begin
    pend_vld = '0;
    for (int l = 0; l < NUM_RAM; l++) begin
      pipe_vld[l] = '0;
      rd_data[l]  = '0;
      pend_pld[l] = '0;
      iss_cnt[l]  = 0;
      cr_cnt[l]   = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    for (int l = 0; l < NUM_RAM; l++) begin
      for (int k = RD_LAT-1; k > 0; k--) begin
        pipe_vld[l][k]  = pipe_vld[l][k-1];
        pipe_data[l][k] = pipe_data[l][k-1];
      end
      pipe_vld[l][0]  = pend_vld[l];
      pipe_data[l][0] = ram_data(l, pend_pld[l]);
      rd_data[l] = pipe_vld[l][RD_LAT-1] ? pipe_data[l][RD_LAT-1] : '0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [NUM_RAM-1:0] prev_hold = '0;
  arb_out_req_t       prev_pld  [NUM_RAM];
  logic [DATA_W-1:0]  prev_data [NUM_RAM];

  always @(negedge clk) begin
    for (int l = 0; l < NUM_RAM; l++) begin
      pend_vld[l] = rd_en[l];
      pend_pld[l] = rd_pld[l];
      if (!rst) begin
        iss_cnt[l] += int'(rd_en[l]);
        cr_cnt[l]  += int'(credit[l]);
        if (prev_hold[l]) begin
          check($sformatf("lane%0d rsp held stable", l),
                CW'({rsp_vld[l], rsp_pld[l], rsp_data[l]}),
                CW'({1'b1, prev_pld[l], prev_data[l]}));
        end
        if (rsp_vld[l] && rsp_rdy[l]) begin
          check($sformatf("lane%0d rsp was expected", l),
                CW'(exp_q[l].size() != 0), CW'(1));
          if (exp_q[l].size() != 0) begin
            check($sformatf("lane%0d rsp pld/data", l),
                  CW'({rsp_pld[l], rsp_data[l]}), CW'(exp_q[l].pop_front()));
          end
        end
        prev_hold[l] = rsp_vld[l] && !rsp_rdy[l];
        prev_pld[l]  = rsp_pld[l];
        prev_data[l] = rsp_data[l];
      end else begin
        prev_hold[l] = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [NUM_RAM-1:0] mask, input logic [NUM_RAM-1:0] keep);
    cmd_vld = mask;
    for (int l = 0; l < NUM_RAM; l++) begin
      if (mask[l]) begin
        cmd_pld[l] = arb_out_req_t'(16'($urandom_range(0, 65535)));
        if (keep[l]) exp_q[l].push_back({cmd_pld[l], ram_data(l, cmd_pld[l])});
      end
    end
  endtask

  task automatic check_idle(input string name);
    check({name, " ram_rd_en"}, CW'(rd_en), CW'(0));
    check({name, " credit"}, CW'(credit), CW'(0));
    check({name, " rd_rsp_vld"}, CW'(rsp_vld), CW'(0));
    check({name, " cmd_ovf_err"}, CW'(ovf_err), CW'(0));
    for (int l = 0; l < NUM_RAM; l++) begin
      check($sformatf("%s lane%0d pld/data", name, l),
            CW'({rd_pld[l], rsp_pld[l], rsp_data[l]}), CW'(0));
    end
  endtask

  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      wr_busy = tbl[i].busy;
      rsp_rdy = tbl[i].rdy;
      drive_push(tbl[i].vld, tbl[i].vld);
      @(negedge clk);
      check($sformatf("row%0d ram_rd_en", i), CW'(rd_en), CW'(tbl[i].en));
      check($sformatf("row%0d credit", i), CW'(credit), CW'(tbl[i].cr));
      check($sformatf("row%0d rd_rsp_vld", i), CW'(rsp_vld), CW'(tbl[i].rsp));
      @(posedge clk);
      #1;
    end
    cmd_vld = '0;
    wr_busy = '0;
    rsp_rdy = '1;
  endtask

  task automatic drain(input int max_cyc, input string name);
    int n;
    n = 0;
    while (!all_empty() && n < max_cyc) begin
      next_cycle();
      n++;
    end
    check({name, " all responses returned"}, CW'(all_empty()), CW'(1));
  endtask

  function automatic vec_t mk(input logic [7:0] vld, input logic [7:0] busy, input logic [7:0] en,
                              input logic [7:0] cr, input logic [7:0] rsp);
    vec_t v;
    v.vld = vld; v.busy = busy; v.rdy = 8'hFF; v.en = en; v.cr = cr; v.rsp = rsp;
    return v;
  endfunction

  // ---------------- test ----------------
  initial begin
    // single read, lane 3 (rows 0-5)
    tbl[0]  = mk(8'h08, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[1]  = mk(8'h00, 8'h00, 8'h08, 8'h08, 8'h00);
    tbl[2]  = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[3]  = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[4]  = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h08);
    tbl[5]  = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    // back-to-back, lane 0 (rows 6-14)
    tbl[6]  = mk(8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[7]  = mk(8'h01, 8'h00, 8'h01, 8'h01, 8'h00);
    tbl[8]  = mk(8'h01, 8'h00, 8'h01, 8'h01, 8'h00);
    tbl[9]  = mk(8'h01, 8'h00, 8'h01, 8'h01, 8'h00);
    tbl[10] = mk(8'h00, 8'h00, 8'h01, 8'h01, 8'h01);
    tbl[11] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
    tbl[12] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
    tbl[13] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
    tbl[14] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    // write-busy block, lane 5 (rows 15-23)
    tbl[15] = mk(8'h20, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[16] = mk(8'h00, 8'h20, 8'h00, 8'h00, 8'h00);
    tbl[17] = mk(8'h00, 8'h20, 8'h00, 8'h00, 8'h00);
    tbl[18] = mk(8'h00, 8'h20, 8'h00, 8'h00, 8'h00);
    tbl[19] = mk(8'h00, 8'h00, 8'h20, 8'h20, 8'h00);
    tbl[20] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[21] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[22] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h20);
    tbl[23] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    rst = 1'b1;
    cmd_vld = '0;
    wr_busy = '0;
    rsp_rdy = '1;
    for (int l = 0; l < NUM_RAM; l++) cmd_pld[l] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;
    next_cycle();

    apply_rows(0, 5);
    apply_rows(6, 14);
    apply_rows(15, 23);

    // backpressure on lane 2
    rsp_rdy = 8'hFB;
    s_iss = iss_cnt[2];
    s_cr  = cr_cnt[2];
    for (int t = 0; t < 8; t++) begin
      drive_push(8'h04, 8'h04);
      next_cycle();
    end
    cmd_vld = '0;
    repeat (8) next_cycle();
    check("bp issues while blocked", CW'(iss_cnt[2] - s_iss), CW'(RSP_DEPTH));
    check("bp credits while blocked", CW'(cr_cnt[2] - s_cr), CW'(RSP_DEPTH));
    @(negedge clk);
    check("bp rsp_vld while blocked", CW'(rsp_vld), CW'(8'h04));
    @(posedge clk);
    #1;
    for (int t = 0; t < 20; t++) begin
      rsp_rdy[2] = 1'($urandom_range(0, 1));
      next_cycle();
    end
    rsp_rdy = '1;
    drain(60, "bp");
    check("bp total issues", CW'(iss_cnt[2] - s_iss), CW'(8));
    check("bp total credits", CW'(cr_cnt[2] - s_cr), CW'(8));

    // overflow on lane 1
    wr_busy = 8'h02;
    s_iss = iss_cnt[1];
    for (int t = 0; t < 5; t++) begin
      drive_push(8'h02, (t < 4) ? 8'h02 : 8'h00);
      next_cycle();
    end
    cmd_vld = '0;
    @(negedge clk);
    check("ovf flag set", CW'(ovf_err), CW'(8'h02));
    check("ovf no issue while busy", CW'(iss_cnt[1] - s_iss), CW'(0));
    @(posedge clk);
    #1;
    repeat (3) next_cycle();
    wr_busy = '0;
    drain(40, "ovf");
    check("ovf kept commands issued", CW'(iss_cnt[1] - s_iss), CW'(CMD_DEPTH));
    @(negedge clk);
    check("ovf flag sticky", CW'(ovf_err), CW'(8'h02));
    @(posedge clk);
    #1;

    // all lanes streaming at one per cycle
    for (int l = 0; l < NUM_RAM; l++) s_all[l] = iss_cnt[l];
    for (int t = 0; t < 6; t++) begin
      drive_push(8'hFF, 8'hFF);
      next_cycle();
    end
    cmd_vld = '0;
    next_cycle();
    for (int l = 0; l < NUM_RAM; l++) begin
      check($sformatf("lane%0d streaming issues", l), CW'(iss_cnt[l] - s_all[l]), CW'(6));
    end
    drain(40, "stream");

    // mid-flight asynchronous reset on lane 3
    drive_push(8'h08, 8'h08);
    next_cycle();
    cmd_vld = '0;
    @(negedge clk);
    check("pre-reset issue", CW'(rd_en), CW'(8'h08));
    @(posedge clk);
    #3;
    rst = 1'b1;
    exp_q[3].delete();
    #1;
    check_idle("async reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      check("no rsp after reset", CW'(rsp_vld), CW'(0));
      @(posedge clk);
      #1;
    end
    apply_rows(0, 5);

    drain(20, "final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: actual=timeout required=completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "bench timed out");
  end

endmodule
